skid_fifo: RTL and testbench

//   Parametrised elastic buffer on the valid/ready stream interface; successor to the 2-entry skid.
//   - Holds DEPTH entries, reports fill level and almost-full, supports synchronous flush.
//   - All upstream/downstream handshake outputs come from registers, so no combinational path

---
 rtl/skid_fifo.sv | 81 ++++++++
 tb/tb_skid_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with fully registered handshake outputs,
// fill level, almost-full and synchronous flush.
module skid_fifo #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_in_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [WIDTH-1:0]           o_out_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_after_pop;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             push;
    logic             pop;

    assign push = i_in_valid & o_in_ready;
    assign pop  = o_out_valid & i_out_ready;

    // The output register mirrors the head entry; when the head slot is the one being
    // written this cycle the incoming word bypasses the array.
    always_comb begin
        count_after_pop = o_count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        rd_ptr_next     = pop ? rd_ptr + PW'(1) : rd_ptr;
        head_next       = (count_after_pop == '0) ? i_in_data : mem[rd_ptr_next];
    end

    always_ff @(posedge i_clock) begin
        if (push && !i_reset && !i_flush) begin
            mem[wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_count       <= '0;
            o_out_valid   <= 1'b0;
            o_out_data    <= '0;
            o_almost_full <= 1'b0;
            o_in_ready    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_count       <= '0;
            o_out_valid   <= 1'b0;
            o_almost_full <= 1'b0;
            o_in_ready    <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr        <= rd_ptr_next;
            o_count       <= count_next;
            o_out_valid   <= (count_next != '0);
            if (count_next != '0) begin
                o_out_data <= head_next;
            end
            o_in_ready    <= (count_next < CW'(DEPTH));
            o_almost_full <= (count_next >= CW'(AFULL_LEVEL));
        end
    end
endmodule

// File: tb/tb_skid_fifo.sv
// Directed self-checking bench for skid_fifo (WIDTH=16, DEPTH=4, AFULL_LEVEL=3).
module tb_skid_fifo;
    logic        clk = 1'b0;
    logic        i_reset, i_flush, i_in_valid, i_out_ready;
    logic [15:0] i_in_data;
    logic        o_in_ready, o_out_valid, o_almost_full;
    logic [15:0] o_out_data;
    logic [2:0]  o_count;

    int passed = 0;
    int total  = 0;

    skid_fifo #(.WIDTH(16), .DEPTH(4), .AFULL_LEVEL(3)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_count(o_count), .o_almost_full(o_almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, got, mcnt;
        logic        stall, do_push, do_pop;
        logic [15:0] held;

        i_reset = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_in_data = '0;

        // 1. reset and idle
        tick(); tick();
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_count", o_count, 0);
        chk("rst_afull", o_almost_full, 0);
        i_reset = 1'b0;
        tick();
        chk("in_ready_after_rst", o_in_ready, 1);
        for (int i = 0; i < 100; i++) begin
            i_out_ready = i[0];
            tick();
            chk("idle_valid", o_out_valid, 0);
            chk("idle_count", o_count, 0);
            chk("idle_in_ready", o_in_ready, 1);
        end

        // 2. fill with 0..3 while stalled, then drain
        i_out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_in_valid = 1'b1; i_in_data = 16'(k - 1);
            tick();
            chk("fill_count", o_count, k);
            chk("fill_afull", o_almost_full, (k >= 3) ? 1 : 0);
            chk("fill_in_ready", o_in_ready, (k < 4) ? 1 : 0);
            chk("fill_valid", o_out_valid, 1);
            chk("fill_head", o_out_data, 0);
        end
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", o_out_valid, 1);
            chk("drain_data", o_out_data, k);
            tick();
            chk("drain_count", o_count, 3 - k);
            chk("drain_in_ready", o_in_ready, 1);
        end
        chk("drain_empty", o_out_valid, 0);

        // 3. sustained streaming at one word per cycle
        for (int k = 0; k < 20; k++) begin
            i_in_valid = 1'b1; i_in_data = 16'(16'h0100 + k);
            tick();
            chk("stream_data", o_out_data, 16'h0100 + k);
            chk("stream_valid", o_out_valid, 1);
            chk("stream_count", o_count, 1);
        end
        i_in_valid = 1'b0;
        tick();
        chk("stream_end_valid", o_out_valid, 0);
        chk("stream_end_count", o_count, 0);

        // 4. bursty ready 1-0-0-1 with continuous input 0..31
        sent = 0; got = 0; mcnt = 0; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && got < 32; cyc++) begin
            i_in_valid  = (sent < 32);
            i_in_data   = 16'(sent);
            i_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            do_push = i_in_valid && o_in_ready;
            do_pop  = o_out_valid && i_out_ready;
            chk("burst_valid", o_out_valid, (mcnt != 0) ? 1 : 0);
            chk("burst_count", o_count, mcnt);
            if (do_pop) begin
                chk("burst_data", o_out_data, got);
                got++;
            end
            stall = o_out_valid && !i_out_ready;
            held  = o_out_data;
            tick();
            if (stall) begin
                chk("burst_hold_data", o_out_data, held);
                chk("burst_hold_valid", o_out_valid, 1);
            end
            if (do_push) sent++;
            mcnt = mcnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        chk("burst_all_received", got, 32);
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("burst_end_count", o_count, 0);

        // 5. full FIFO with a single ready cycle
        i_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_in_valid = 1'b1; i_in_data = 16'(200 + k);
            tick();
        end
        chk("full_count", o_count, 4);
        i_in_data = 16'd204; i_out_ready = 1'b1;
        chk("full_in_ready_pop_cycle", o_in_ready, 0);
        tick();
        chk("full_after_pop_count", o_count, 3);
        chk("full_after_pop_in_ready", o_in_ready, 1);
        chk("full_after_pop_head", o_out_data, 201);
        i_out_ready = 1'b0;
        tick();
        chk("full_refill_count", o_count, 4);
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("full_drain_valid", o_out_valid, 1);
            chk("full_drain_data", o_out_data, 200 + k);
            tick();
        end
        chk("full_drain_empty", o_out_valid, 0);

        // 6a. flush with a simultaneous push
        i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_in_valid = 1'b1; i_in_data = 16'(16'h0010 + k);
            tick();
        end
        chk("pre_flush_count", o_count, 3);
        i_in_data = 16'hAAAA; i_flush = 1'b1;
        tick();
        i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
        chk("flush_count", o_count, 0);
        chk("flush_valid", o_out_valid, 0);
        chk("flush_afull", o_almost_full, 0);
        chk("flush_in_ready", o_in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_flush_valid", o_out_valid, 0);
        end

        // 6b. reset mid-stream with a simultaneous push
        i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_in_valid = 1'b1; i_in_data = 16'(16'h0020 + k);
            tick();
        end
        chk("pre_rst_count", o_count, 3);
        i_in_data = 16'hAAAA; i_reset = 1'b1;
        tick();
        chk("midrst_in_ready", o_in_ready, 0);
        chk("midrst_count", o_count, 0);
        chk("midrst_valid", o_out_valid, 0);
        chk("midrst_afull", o_almost_full, 0);
        tick();
        chk("midrst_hold_in_ready", o_in_ready, 0);
        i_reset = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
        tick();
        chk("post_rst_in_ready", o_in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_valid", o_out_valid, 0);
            chk("post_rst_count", o_count, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
